// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: two-flop sync, tick-gated debounce,
// press/release strobes and a hold-to-repeat strobe per channel.
module button_conditioner #(
  parameter int CHANNELS     = 5,
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  // release/repeat are reserved words, hence the _pulse names
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int DW   = $clog2(STABLE_TICKS + 1);
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] D_LAST = DW'(STABLE_TICKS - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [HW-1:0] L_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_TICKS - 1);
  localparam logic [HW-1:0] H_ONE  = HW'(1);

  typedef enum logic [1:0] {IDLE, WAIT_LONG, REPEATING} state_t;

  logic [CHANNELS-1:0] s1, s2, level_d, repeat_r;
  logic [CHANNELS-1:0] accept, rise, fall;
  logic [DW-1:0]       dcnt  [CHANNELS];
  logic [HW-1:0]       hcnt  [CHANNELS];
  state_t              state [CHANNELS];

  // The FSM reacts on the same edge the debounced level changes, so it
  // uses the accept decision rather than the registered level.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      accept[i] = tick && (s2[i] != level[i]) && (dcnt[i] == D_LAST);
    end
  end

  assign rise = accept & s2;
  assign fall = accept & ~s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      level    <= '0;
      level_d  <= '0;
      repeat_r <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        dcnt[i]  <= '0;
        hcnt[i]  <= '0;
        state[i] <= IDLE;
      end
    end else begin
      s1       <= in;
      s2       <= s1;
      level_d  <= level;
      repeat_r <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (tick) begin
          if ((s2[i] == level[i]) || accept[i]) dcnt[i] <= '0;
          else                                  dcnt[i] <= dcnt[i] + D_ONE;
        end
        if (accept[i]) level[i] <= s2[i];

        if (fall[i]) begin
          state[i] <= IDLE;
          hcnt[i]  <= '0;
        end else if (rise[i]) begin
          state[i] <= WAIT_LONG;
          hcnt[i]  <= '0;
        end else if (tick && level[i]) begin
          case (state[i])
            WAIT_LONG: begin
              if (hcnt[i] == L_LAST) begin
                repeat_r[i] <= 1'b1;
                hcnt[i]     <= '0;
                state[i]    <= REPEATING;
              end else begin
                hcnt[i] <= hcnt[i] + H_ONE;
              end
            end
            REPEATING: begin
              if (hcnt[i] == R_LAST) begin
                repeat_r[i] <= 1'b1;
                hcnt[i]     <= '0;
              end else begin
                hcnt[i] <= hcnt[i] + H_ONE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign press         = level & ~level_d;
  assign release_pulse = ~level & level_d;
  assign repeat_pulse  = repeat_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus,
// checked every cycle against a sample-history reference model.
module tb_button_conditioner;

  localparam int CH = 2;
  localparam int ST = 4;
  localparam int LT = 8;
  localparam int RT = 3;

  logic          clk = 1'b0;
  logic          reset, tick;
  logic [CH-1:0] in;
  logic [CH-1:0] level, press, release_pulse, repeat_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [CH-1:0] m_s1, m_s2, m_lvl, m_lvld, m_rep;
  logic [ST-1:0] hist [CH];
  int            held [CH];

  button_conditioner #(
    .CHANNELS    (CH),
    .STABLE_TICKS(ST),
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .in           (in),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Level flips once the last ST tick samples all disagree with it; the
  // repeat strobe fires at held == LT, LT+RT, LT+2*RT, ... ticks of holding.
  task automatic model_edge(input logic [CH-1:0] i, input logic t, input logic r);
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvld = '0; m_rep = '0;
      for (int c = 0; c < CH; c++) begin
        hist[c] = '0;
        held[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        logic nl, rp;
        nl = m_lvl[c];
        rp = 1'b0;
        if (t) begin
          hist[c] = {hist[c][ST-2:0], m_s2[c]};
          if ((hist[c] ^ {ST{m_lvl[c]}}) == '1) nl = ~m_lvl[c];
        end
        if (nl && !m_lvl[c]) held[c] = 0;
        else if (nl && m_lvl[c] && t) begin
          held[c]++;
          if (held[c] == LT || (held[c] > LT && (held[c] - LT) % RT == 0)) rp = 1'b1;
        end
        m_rep[c]  = rp;
        m_lvld[c] = m_lvl[c];
        m_lvl[c]  = nl;
        m_s2[c]   = m_s1[c];
        m_s1[c]   = i[c];
      end
    end
  endtask

  task automatic step(input logic [CH-1:0] i, input logic t, input logic r);
    in = i; tick = t; reset = r;
    @(posedge clk);
    model_edge(i, t, r);
    #1;
    chk("level",   level,         m_lvl);
    chk("press",   press,         m_lvl & ~m_lvld);
    chk("release", release_pulse, ~m_lvl & m_lvld);
    chk("repeat",  repeat_pulse,  m_rep);
  endtask

  initial begin
    int reps;
    logic [CH-1:0] rin;
    in = '0; tick = 1'b0; reset = 1'b1;

    // Reset state
    step(2'b00, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b1);
    chk("rst_level", level, 2'b00);
    chk("rst_strobes", press | release_pulse | repeat_pulse, 2'b00);

    // Clean step on channel 0
    for (int e = 1; e <= 12; e++) begin
      step(2'b01, 1'b1, 1'b0);
      if (e == 5) chk("clean_lvl_e5", level, 2'b00);
      if (e == 6) begin
        chk("clean_lvl_e6", level, 2'b01);
        chk("clean_press_e6", press, 2'b01);
      end
      if (e == 7) chk("clean_press_e7", press, 2'b00);
    end
    for (int e = 0; e < 12; e++) step(2'b00, 1'b1, 1'b0);

    // Bounce: 3 high / 1 low never stays stable long enough
    step(2'b00, 1'b1, 1'b1);
    for (int k = 0; k < 40; k++) step({1'b0, (k % 4) != 3}, 1'b1, 1'b0);
    chk("bounce_level", level, 2'b00);
    for (int k = 0; k < 12; k++) step(2'b01, 1'b1, 1'b0);
    chk("bounce_settled", level, 2'b01);

    // Hold and release
    step(2'b00, 1'b1, 1'b1);
    reps = 0;
    for (int e = 1; e <= 24; e++) begin
      step(2'b01, 1'b1, 1'b0);
      if (e <= 23 && repeat_pulse[0]) reps++;
    end
    chk_int("hold_repeats_by_e23", reps, 4);
    for (int e = 25; e <= 36; e++) step(2'b00, 1'b1, 1'b0);
    chk("hold_released", level, 2'b00);

    // Tick gating with short glitches between ticks, then a steady step
    step(2'b00, 1'b1, 1'b1);
    for (int k = 0; k < 64; k++) begin
      if (k < 24) step({1'b0, (k % 4) == 0}, (k % 4) == 3, 1'b0);
      else        step(2'b01, (k % 4) == 3, 1'b0);
      if (k == 23) chk("gate_glitch_ignored", level, 2'b00);
    end
    chk("gate_step_accepted", level, 2'b01);

    // Reset while repeating
    step(2'b00, 1'b1, 1'b1);
    for (int e = 0; e < 20; e++) step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b1);
    chk("midrst_level", level, 2'b00);
    chk("midrst_strobes", press | release_pulse | repeat_pulse, 2'b00);
    for (int e = 1; e <= 8; e++) begin
      step(2'b01, 1'b1, 1'b0);
      if (e == 5) chk("midrst_lvl_e5", level, 2'b00);
      if (e == 6) chk("midrst_press_e6", press, 2'b01);
    end

    // Simultaneous channels
    step(2'b00, 1'b1, 1'b1);
    for (int e = 1; e <= 10; e++) begin
      step(2'b11, 1'b1, 1'b0);
      if (e == 6) chk("simul_press", press, 2'b11);
    end
    for (int e = 1; e <= 10; e++) begin
      step(2'b01, 1'b1, 1'b0);
      if (e == 6) chk("simul_release", release_pulse, 2'b10);
    end

    // Random stimulus
    rin = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) rin[c] = ~rin[c];
      step(rin, $urandom_range(0, 2) != 0, $urandom_range(0, 499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
